// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word-fall-through read port,
// fill level, full/empty and sticky overrun. Define UART_RX_FIFO_IRQ_EN to build the level irq.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int IRQ_LEVEL = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_stb,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overrun,
  input  logic          clr_overrun,
  output logic          irq
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  // Elaboration-time guard on the parameter set.
  if (DEPTH != (1 << AW) || DEPTH < 2) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be 2**AW and >= 2");
  end
  if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_level
    $error("uart_rx_fifo: IRQ_LEVEL must be within 1..DEPTH");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_next;
  logic          overrun_q;
  logic          overrun_next;
  logic          push;
  logic          pop;

  // Status is decoded from the registered count only, so no input reaches these outputs.
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_COUNT);
  assign rd_valid = !empty;
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr];

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pop  = rd_valid & rd_ready;
  assign push = wr_stb & (!full | pop);

  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + ONE_COUNT;
    end else if (pop && !push) begin
      count_next = count_q - ONE_COUNT;
    end
  end

  // A dropped byte sets the flag; setting takes priority over a simultaneous clear.
  assign overrun_next = (overrun_q & ~clr_overrun) | (wr_stb & ~push);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      count_q   <= count_next;
      overrun_q <= overrun_next;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [AW:0] IRQ_COUNT = (AW + 1)'(IRQ_LEVEL);
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= (count_next >= IRQ_COUNT) | overrun_next;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a negedge monitor
// compares every accepted head byte; status is checked against a small occupancy model.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_stb = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  logic       irq;

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];
  int         model_cnt = 0;
  bit         model_ovr = 1'b0;

  uart_rx_fifo #(.DEPTH(16), .AW(4), .IRQ_LEVEL(8)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_stb(wr_stb),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .empty(empty), .full(full), .overrun(overrun),
    .clr_overrun(clr_overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every handshake must deliver the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got 0x%0h expected no byte at %0t", rd_data, $time);
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_status(input string tag);
    check({tag, ".count"},    32'(count),    32'(model_cnt));
    check({tag, ".empty"},    32'(empty),    32'(model_cnt == 0));
    check({tag, ".full"},     32'(full),     32'(model_cnt == 16));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(model_cnt != 0));
    check({tag, ".overrun"},  32'(overrun),  32'(model_ovr));
    check({tag, ".irq"},      32'(irq),      32'(IRQ_ON & ((model_cnt >= 8) | model_ovr)));
    if (model_cnt == 0) check({tag, ".rd_data_idle"}, 32'(rd_data), 32'h00);
  endtask

  // One clock of stimulus; inputs change 1 time unit after the edge.
  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit pop_m, push_m;
    pop_m  = (model_cnt > 0) && r;
    push_m = w && ((model_cnt < 16) || pop_m);
    if (push_m) exp_q.push_back(d);
    model_ovr = (model_ovr && !c) || (w && !push_m);
    model_cnt = model_cnt + int'(push_m) - int'(pop_m);
    wr_stb = w; wr_data = d; rd_ready = r; clr_overrun = c;
    @(posedge clk);
    #1;
    wr_stb = 1'b0; rd_ready = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic apply_reset(input logic w, input logic r);
    rst = 1'b1; wr_stb = w; wr_data = 8'hEE; rd_ready = r;
    @(posedge clk);
    #1;
    rst = 1'b0; wr_stb = 1'b0; rd_ready = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    model_ovr = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (model_cnt > 0) drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_status(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushes;

    // 1: reset state
    apply_reset(1'b0, 1'b0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full", 32'(full), 32'd0);
    check("rst.rd_valid", 32'(rd_valid), 32'd0);
    check("rst.rd_data", 32'(rd_data), 32'h00);
    check("rst.overrun", 32'(overrun), 32'd0);
    check("rst.irq", 32'(irq), 32'd0);

    // 2: single byte fall-through, then pop; empty + push + ready is push only
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    check("t2.rd_valid", 32'(rd_valid), 32'd1);
    check("t2.rd_data", 32'(rd_data), 32'hA5);
    check("t2.count", 32'(count), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2.empty", 32'(empty), 32'd1);
    check("t2.rd_data0", 32'(rd_data), 32'h00);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("t2.idle_ready");

    // 3: fill, overflow drop, drain in order
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    check("t3.full", 32'(full), 32'd1);
    check("t3.count", 32'(count), 32'd16);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    check("t3.overrun", 32'(overrun), 32'd1);
    check("t3.count_after_drop", 32'(count), 32'd16);
    drain("t3.drained");
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("t3.overrun_cleared", 32'(overrun), 32'd0);

    // 4: full + push + pop in the same cycle
    for (int i = 0; i < 16; i++) drive(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    check("t4.count", 32'(count), 32'd16);
    check("t4.head", 32'(rd_data), 32'h21);
    check("t4.overrun", 32'(overrun), 32'd0);
    drain("t4.drained");

    // 5: wrap with toggling ready, then set-vs-clear priority on overrun
    pushes = 0;
    for (int i = 0; i < 90; i++) begin
      drive(((i % 2) == 0) && (pushes < 40), 8'h80 + 8'(pushes), (i % 3) != 2, 1'b0);
      if (((i % 2) == 0) && (pushes < 40)) pushes++;
      check_status("t5.wrap");
    end
    drain("t5.drained");
    for (int i = 0; i < 16; i++) drive(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h99, 1'b0, 1'b1);
    check("t5.set_beats_clr", 32'(overrun), 32'd1);
    drive(1'b1, 8'h9A, 1'b0, 1'b1);
    check("t5.set_beats_clr_again", 32'(overrun), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("t5.clr", 32'(overrun), 32'd0);
    drain("t5.drained2");

    // 6: irq threshold and mid-stream reset
    for (int i = 0; i < 7; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    check("t6.irq_at7", 32'(irq), 32'd0);
    drive(1'b1, 8'hC7, 1'b0, 1'b0);
    check("t6.irq_at8", 32'(irq), 32'(IRQ_ON));
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6.irq_after_pop", 32'(irq), 32'd0);
    check_status("t6.level7");
    drain("t6.drained");
    for (int i = 0; i < 5; i++) drive(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    check("t6.count5", 32'(count), 32'd5);
    apply_reset(1'b1, 1'b1);
    check("t6.rst_count", 32'(count), 32'd0);
    check("t6.rst_empty", 32'(empty), 32'd1);
    check("t6.rst_rd_valid", 32'(rd_valid), 32'd0);
    check("t6.rst_rd_data", 32'(rd_data), 32'h00);
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    check("t6.post_rst_head", 32'(rd_data), 32'h3C);
    drain("t6.final");

    check("sb.leftover", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
